// File: rtl/mips_lsu_if.sv
// ---------------------------------------------------------------------------
// mips_lsu_if
// Bundles the mips_lsu request/response handshake and its word-wide memory
// port.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. The requester holds req_valid and the req_* fields
// stable until that edge. resp_valid is a one-cycle pulse with no
// back-pressure. misaligned and resp_rdata are meaningful only while
// resp_valid is 1.
//
// Modports
//   slave  : the LSU side (takes requests, drives the memory port)
//   master : the core/memory side (issues requests, returns read data)
// ---------------------------------------------------------------------------
interface mips_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_write_en;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  mem_data_out,
        output req_ready, resp_valid, resp_rdata, misaligned,
        output mem_addr, mem_data_in, mem_write_en
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output mem_data_out,
        input  req_ready, resp_valid, resp_rdata, misaligned,
        input  mem_addr, mem_data_in, mem_write_en
    );
endinterface

// File: rtl/mips_lsu.sv
// ---------------------------------------------------------------------------
// mips_lsu
// Load/store unit between the core datapath and a big-endian byte-lane data
// memory (4 x 8-bit lanes, lane 0 = bits [31:24]). It executes one
// lb/lbu/lh/lhu/lw/sb/sh/sw at a time. Sub-word stores are done as
// read-modify-write because the memory only has a whole-word write enable.
// Misaligned requests are answered at once and never reach memory.
//
// Ports
//   clk        clock, rising edge
//   rst_b      asynchronous active-low reset
//   bus        mips_lsu_if.slave: request/response handshake + memory port
//   state_dbg  current FSM state (0 IDLE, 1 RD_WAIT, 2 WRITE)
//
// Parameter
//   MEM_LATENCY  cycles from mem_addr to valid mem_data_out, 1..15
// ---------------------------------------------------------------------------
module mips_lsu #(
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_b,
    mips_lsu_if.slave     bus,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        mis_req;
    logic        cnt_done;

    assign accept   = bus.req_valid && bus.req_ready;
    assign cnt_done = (cnt_q == 4'd0);
    assign mis_req  = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00)) ||
                      (bus.req_size == 2'd3);

    assign state_dbg = state_q;

    // Pick the addressed byte/half out of a big-endian word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        sgn);
        logic [31:0] sh;
        logic [31:0] res;
        res = word;
        if (size == 2'd0) begin
            sh  = word >> {2'd3 - off, 3'b000};
            res = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
        end else if (size == 2'd1) begin
            sh  = word >> {~off[1], 4'b0000};
            res = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
        end
        return res;
    endfunction

    // Replace the addressed byte/half lane of the read word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] mask;
        logic [31:0] data;
        if (size == 2'd0) begin
            mask = 32'h0000_00FF << {2'd3 - off, 3'b000};
            data = {24'h0, wdata[7:0]} << {2'd3 - off, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {~off[1], 4'b0000};
            data = {16'h0, wdata[15:0]} << {~off[1], 4'b0000};
        end
        return (word & ~mask) | (data & mask);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Misaligned requests stay in IDLE; word stores need
    // no read and go straight to WRITE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !mis_req) begin
                    if (bus.req_we && (bus.req_size == 2'd2)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_done) begin
                    state_d = we_q ? WRITE : IDLE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.req_ready    = 1'b0;
        bus.mem_write_en = 1'b0;
        case (state_q)
            IDLE:    bus.req_ready    = 1'b1;
            WRITE:   bus.mem_write_en = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers. resp_valid is raised on the edge that returns the
    // FSM to IDLE (or keeps it there for a misaligned request), so the
    // response cycle is also a cycle in which a new request can be accepted.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q           <= 4'd0;
            we_q            <= 1'b0;
            signed_q        <= 1'b0;
            size_q          <= 2'd0;
            off_q           <= 2'd0;
            wdata_q         <= 32'h0;
            bus.resp_valid  <= 1'b0;
            bus.resp_rdata  <= 32'h0;
            bus.misaligned  <= 1'b0;
            bus.mem_addr    <= 32'h0;
            bus.mem_data_in <= 32'h0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.misaligned <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q     <= bus.req_we;
                        signed_q <= bus.req_signed;
                        size_q   <= bus.req_size;
                        off_q    <= bus.req_addr[1:0];
                        wdata_q  <= bus.req_wdata;
                        cnt_q    <= 4'(MEM_LATENCY - 1);
                        if (mis_req) begin
                            bus.resp_valid <= 1'b1;
                            bus.misaligned <= 1'b1;
                            bus.resp_rdata <= 32'h0;
                        end else begin
                            bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
                            if (bus.req_we && (bus.req_size == 2'd2)) begin
                                bus.mem_data_in <= bus.req_wdata;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_done) begin
                        if (we_q) begin
                            bus.mem_data_in <= store_merge(bus.mem_data_out, wdata_q,
                                                           size_q, off_q);
                        end else begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= load_extract(bus.mem_data_out, size_q,
                                                           off_q, signed_q);
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WRITE: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= 32'h0;
                end
                default: ;
            endcase
        end
    end

endmodule
